// File: rtl/text_buffer_reader.sv
// Streams a ROWS x COLS character RAM to a valid/ready transmitter, one character per fetch.
// Optional macro TEXT_READER_CRLF_EN appends CR, LF after each row.
`timescale 1ns/1ps
module text_buffer_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [$clog2(ROWS)-1:0]  r_row,
  output logic [$clog2(COLS)-1:0]  r_col,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
`ifdef TEXT_READER_CRLF_EN
  localparam logic [DATA_WIDTH-1:0] CH_CR = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_LF = DATA_WIDTH'(8'h0A);
`endif

`ifdef TEXT_READER_CRLF_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, CAPTURE = 3'd2, SEND = 3'd3, CR = 3'd4, LF = 3'd5, DONE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, CAPTURE = 3'd2, SEND = 3'd3, DONE = 3'd6
  } state_t;
`endif

  // Unwritten cells read as NUL; show them as blanks.
  function automatic logic [DATA_WIDTH-1:0] blank_fill(input logic [DATA_WIDTH-1:0] c);
    return (c == '0) ? CH_SPACE : c;
  endfunction

  state_t                  state_r, state_s;
  logic [RW-1:0]           row_r, row_s, row_adv_s;
  logic [CW-1:0]           col_r, col_s;
  logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_s;
  logic                    tx_valid_r, tx_valid_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    last_row_s;
  state_t                  row_end_state_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r      <= '0;
      col_r      <= '0;
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      row_r      <= row_s;
      col_r      <= col_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_s         = state_r;
    row_s           = row_r;
    col_s           = col_r;
    tx_data_s       = tx_data_r;
    tx_valid_s      = tx_valid_r;
    busy_s          = busy_r;
    done_s          = 1'b0;
    last_row_s      = (row_r == ROW_LAST);
    row_adv_s       = last_row_s ? row_r : row_r + RW'(1);
    row_end_state_s = last_row_s ? DONE : FETCH;
    case (state_r)
      IDLE: begin
        if (start) begin
          row_s   = '0;
          col_s   = '0;
          busy_s  = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        tx_data_s  = blank_fill(rd_data);
        tx_valid_s = 1'b1;
        state_s    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (col_r == COL_LAST) begin
            col_s = '0;
`ifdef TEXT_READER_CRLF_EN
            tx_data_s = CH_CR;
            state_s   = CR;
`else
            // Last column of the row: advance row or finish.
            tx_valid_s = 1'b0;
            row_s      = row_adv_s;
            busy_s     = !last_row_s;
            done_s     = last_row_s;
            state_s    = row_end_state_s;
`endif
          end else begin
            col_s      = col_r + CW'(1);
            tx_valid_s = 1'b0;
            state_s    = FETCH;
          end
        end else begin
          state_s = SEND;
        end
      end
`ifdef TEXT_READER_CRLF_EN
      CR: begin
        if (tx_ready) begin
          tx_data_s = CH_LF;
          state_s   = LF;
        end else begin
          state_s = CR;
        end
      end
      LF: begin
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          row_s      = row_adv_s;
          busy_s     = !last_row_s;
          done_s     = last_row_s;
          state_s    = row_end_state_s;
        end else begin
          state_s = LF;
        end
      end
`endif
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  assign r_row    = row_r;
  assign r_col    = col_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_text_buffer_reader.sv
// Scoreboard bench for text_buffer_reader: a 3x5 instance for handshake/reset corners
// and a default 4x32 instance for full-buffer dumps.
`timescale 1ns/1ps
module tb_text_buffer_reader;
  localparam int AR = 3, AC = 5, BR = 4, BC = 32;
`ifdef TEXT_READER_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int ADUMP = AR * (AC + EXTRA);
  localparam int BDUMP = BR * (BC + EXTRA);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_a, start_b, tx_ready_a, tx_ready_b;
  logic [1:0] r_row_a, r_row_b;
  logic [2:0] r_col_a;
  logic [4:0] r_col_b;
  logic [7:0] rd_data_a, rd_data_b, tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b, busy_a, busy_b, done_a, done_b;

  text_buffer_reader #(.DATA_WIDTH(8), .ROWS(AR), .COLS(AC)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .r_row(r_row_a), .r_col(r_col_a),
    .rd_data(rd_data_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .done(done_a));

  text_buffer_reader dut_b (
    .clk(clk), .reset(reset), .start(start_b), .r_row(r_row_b), .r_col(r_col_b),
    .rd_data(rd_data_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b));

  logic [7:0] mem_a [AR*AC];
  logic [7:0] mem_b [BR*BC];

  // Synchronous-read character RAMs.
  always @(posedge clk) begin
    int ia, ib;
    ia = int'(r_row_a) * AC + int'(r_col_a);
    ib = int'(r_row_b) * BC + int'(r_col_b);
    rd_data_a <= (ia < AR*AC) ? mem_a[ia] : 8'h00;
    rd_data_b <= (ib < BR*BC) ? mem_b[ib] : 8'h00;
  end

  int checks = 0, passes = 0;
  int acc_a = 0, acc_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_char(input logic [7:0] c);
    return (c == 8'h00) ? 8'h20 : c;
  endfunction

  task automatic push_dump_a();
    for (int r = 0; r < AR; r++) begin
      for (int c = 0; c < AC; c++) qa.push_back(exp_char(mem_a[r*AC+c]));
      if (EXTRA != 0) begin qa.push_back(8'h0D); qa.push_back(8'h0A); end
    end
  endtask

  task automatic push_dump_b();
    for (int r = 0; r < BR; r++) begin
      for (int c = 0; c < BC; c++) qb.push_back(exp_char(mem_b[r*BC+c]));
      if (EXTRA != 0) begin qb.push_back(8'h0D); qb.push_back(8'h0A); end
    end
  endtask

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (!reset) begin
      check("a_addr_in_range", int'(r_row_a < 2'(AR) && r_col_a < 3'(AC)), 1);
      if (done_a) begin
        done_cnt_a++;
        check("a_busy_low_with_done", busy_a, 0);
      end
      if (tx_valid_a && tx_ready_a) begin
        acc_a++;
        if (qa.size() == 0) check("a_extra_char", tx_data_a, 256);
        else check("a_char", tx_data_a, qa.pop_front());
      end
    end
  end

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_b) begin
        done_cnt_b++;
        check("b_busy_low_with_done", busy_b, 0);
      end
      if (tx_valid_b && tx_ready_b) begin
        acc_b++;
        if (qb.size() == 0) check("b_extra_char", tx_data_b, 256);
        else check("b_char", tx_data_b, qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin tick(); n++; end
    if (!done_a) check("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    while (!done_b && n < budget) begin tick(); n++; end
    if (!done_b) check("b_done_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, acc0, n;
    logic [7:0] held;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_ready_a = 1'b1; tx_ready_b = 1'b1;
    for (int i = 0; i < AR*AC; i++) mem_a[i] = 8'h41 + 8'(i % 26);
    mem_a[3] = 8'h00;
    mem_a[9] = 8'h00;
    for (int i = 0; i < BR*BC; i++) mem_b[i] = 8'h00;
    #3;
    check("rst_tx_valid", tx_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_r_row", r_row_a, 0);
    check("rst_r_col", r_col_a, 0);
    check("rst_b_busy", busy_b, 0);
    tick(); tick();

    // Dump 1: start on the very first edge after reset release.
    reset = 1'b0;
    push_dump_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
    lat = 1;
    while (!tx_valid_a && lat < 10) begin tick(); lat++; end
    check("a_first_valid_latency", lat, 3);
    check("a_first_char", tx_data_a, 8'h41);
    tick(); tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done_a(400);
    start_a = 1'b1;
    check("a_busy_in_done_cycle", busy_a, 0);
    tick();
    start_a = 1'b0;
    check("a_done_one_cycle", done_a, 0);
    check("a_start_in_done_ignored", busy_a, 0);
    repeat (5) tick();
    check("a_dump1_count", acc_a, ADUMP);
    check("a_dump1_done_count", done_cnt_a, 1);
    check("a_dump1_queue_empty", qa.size(), 0);

    // Dump 2: stall on the 5th character.
    acc0 = acc_a;
    push_dump_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (acc_a < acc0 + 4 && n < 100) begin tick(); n++; end
    tx_ready_a = 1'b0;
    n = 0;
    while (!tx_valid_a && n < 10) begin tick(); n++; end
    held = tx_data_a;
    check("a_stall_fifth_char", held, 8'h45);
    repeat (9) begin
      tick();
      check("a_stall_valid_held", tx_valid_a, 1);
      check("a_stall_data_held", tx_data_a, held);
    end
    tx_ready_a = 1'b1;
    wait_done_a(400);
    tick();
    check("a_dump2_count", acc_a - acc0, ADUMP);
    check("a_dump2_done_count", done_cnt_a, 2);

    // Dump 3: asynchronous reset while in row 2.
    acc0 = acc_a;
    mem_a[0] = 8'h5A;
    push_dump_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (acc_a < acc0 + 2*(AC+EXTRA) + 1 && n < 200) begin tick(); n++; end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("a_midreset_tx_valid", tx_valid_a, 0);
    check("a_midreset_busy", busy_a, 0);
    check("a_midreset_r_row", r_row_a, 0);
    check("a_midreset_r_col", r_col_a, 0);
    qa.delete();
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    check("a_midreset_no_done", done_cnt_a, 2);

    // Dump 4: restart begins at row 0, col 0.
    acc0 = acc_a;
    push_dump_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!tx_valid_a && n < 10) begin tick(); n++; end
    check("a_restart_first_char", tx_data_a, 8'h5A);
    wait_done_a(400);
    tick();
    check("a_dump4_count", acc_a - acc0, ADUMP);
    check("a_dump4_done_count", done_cnt_a, 3);

    // Default instance: blank RAM, then lettered RAM.
    push_dump_b();
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done_b(3000);
    tick();
    check("b_blank_count", acc_b, BDUMP);
    check("b_blank_done_count", done_cnt_b, 1);
    check("b_blank_busy_after", busy_b, 0);
    for (int i = 0; i < BR*BC; i++) mem_b[i] = 8'h41 + 8'(i % 26);
    push_dump_b();
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (20) tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done_b(3000);
    tick();
    check("b_letters_count", acc_b, 2 * BDUMP);
    check("b_letters_done_count", done_cnt_b, 2);
    check("b_letters_busy_after", busy_b, 0);
    check("b_queue_empty", qb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
